// File: rtl/bowling_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bowling_pkg
//  Description : Shared types and constants for the bowling scorer: FSM state
//                encoding, pin/score widths and active-low seven-segment
//                digit patterns (bit order gfedcba).
//  Revision    : 1.0 - initial release
// ============================================================================
package bowling_pkg;

    typedef enum logic [1:0] {
        S_ROLL1 = 2'd0,
        S_ROLL2 = 2'd1,
        S_FILL  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [3:0] PINS      = 4'd10;
    localparam int         SCORE_W   = 9;
    localparam int         MAX_SCORE = 300;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // BCD digit to active-low segment pattern; non-decimal codes go dark.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = SEG_0;
            4'd1:    seg7 = SEG_1;
            4'd2:    seg7 = SEG_2;
            4'd3:    seg7 = SEG_3;
            4'd4:    seg7 = SEG_4;
            4'd5:    seg7 = SEG_5;
            4'd6:    seg7 = SEG_6;
            4'd7:    seg7 = SEG_7;
            4'd8:    seg7 = SEG_8;
            4'd9:    seg7 = SEG_9;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_hex3.sv
`default_nettype none
// ============================================================================
//  Module      : score_hex3
//  Description : Combinational 9-bit binary to three active-low 7-segment
//                digits (hundreds, tens, ones). Hundreds digit is blanked
//                when the value is below 100.
//  Ports       : score [8:0] in  - binary value
//                hex2/hex1/hex0 [6:0] out - hundreds/tens/ones, gfedcba
//  Revision    : 1.0 - initial release
// ============================================================================
module score_hex3
    import bowling_pkg::*;
(
    input  logic [SCORE_W-1:0] score,
    output logic [6:0]         hex2,
    output logic [6:0]         hex1,
    output logic [6:0]         hex0
);

    logic [11:0] bcd;

    // Double-dabble: before each shift, any BCD digit >= 5 gets +3 so that
    // the shift carries correctly into the next decade.
    always_comb begin
        bcd = 12'd0;
        for (int i = SCORE_W - 1; i >= 0; i--) begin
            if (bcd[3:0]  >= 4'd5) bcd[3:0]  = bcd[3:0]  + 4'd3;
            if (bcd[7:4]  >= 4'd5) bcd[7:4]  = bcd[7:4]  + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], score[i]};
        end
    end

    assign hex2 = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
    assign hex1 = seg7(bcd[7:4]);
    assign hex0 = seg7(bcd[3:0]);

endmodule
`default_nettype wire

// File: rtl/bowling_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : bowling_scoreboard
//  Description : Multi-player ten-pin bowling scorer. Accepts one pin count
//                per roll, applies strike/spare bonuses via per-player bonus
//                multipliers, tracks turn/frame progression including the
//                final-frame fill ball, and displays a selected player's
//                running total on three seven-segment digits.
//  Ports       : CLOCK_50, reset (async, active-high), new_game (sync clear)
//                roll_valid/roll_pins/roll_ready/roll_err - roll handshake
//                disp_sel -> disp_score, HEX2..HEX0 (combinational)
//                cur_player, cur_frame, roll_num, game_over - status
//  Revision    : 1.0 - initial release
// ============================================================================
module bowling_scoreboard
    import bowling_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_FRAMES  = 10
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               new_game,
    input  logic               roll_valid,
    input  logic [3:0]         roll_pins,
    output logic               roll_ready,
    output logic               roll_err,
    input  logic [1:0]         disp_sel,
    output logic [SCORE_W-1:0] disp_score,
    output logic [1:0]         cur_player,
    output logic [3:0]         cur_frame,
    output logic [1:0]         roll_num,
    output logic               game_over,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX0
);

    // Arrays are always sized for the maximum of four players; slots beyond
    // NUM_PLAYERS are never indexed by cur_player and simply stay zero.
    localparam int         MAXP        = 4;
    localparam logic [1:0] LAST_PLAYER = 2'(NUM_PLAYERS - 1);
    localparam logic [3:0] LAST_FRAME  = 4'(NUM_FRAMES - 1);
    localparam logic [2:0] NP          = 3'(NUM_PLAYERS);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q [MAXP];
    logic [SCORE_W-1:0] score_d [MAXP];
    logic [1:0]         b1_q [MAXP];
    logic [1:0]         b1_d [MAXP];
    logic               b2_q [MAXP];
    logic               b2_d [MAXP];
    logic [3:0]         standing_q, standing_d;
    logic [3:0]         cur_frame_q, cur_frame_d;
    logic [1:0]         cur_player_q, cur_player_d;
    logic [1:0]         roll_num_q, roll_num_d;
    logic               strike1_q, strike1_d;
    logic               roll_err_q, roll_err_d;

    logic               accept;
    logic               legal;
    logic               final_frame;
    logic               all_down;
    logic               end_turn;
    logic [4:0]         prod;
    logic [3:0]         left_after;
    logic [3:0]         fresh_left;

    assign roll_ready  = (state_q != S_OVER);
    assign accept      = roll_valid && roll_ready;
    assign legal       = (roll_pins <= standing_q);
    assign final_frame = (cur_frame_q == LAST_FRAME);
    assign all_down    = (roll_pins == PINS);
    // b1 is at most 2, so the weighted pin count never exceeds 30.
    assign prod        = {1'b0, roll_pins} * ({3'b000, b1_q[cur_player_q]} + 5'd1);
    assign left_after  = standing_q - roll_pins;
    assign fresh_left  = PINS - roll_pins;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= S_ROLL1;
            for (int i = 0; i < MAXP; i++) begin
                score_q[i] <= '0;
                b1_q[i]    <= 2'd0;
                b2_q[i]    <= 1'b0;
            end
            standing_q   <= PINS;
            cur_frame_q  <= 4'd0;
            cur_player_q <= 2'd0;
            roll_num_q   <= 2'd0;
            strike1_q    <= 1'b0;
            roll_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < MAXP; i++) begin
                score_q[i] <= score_d[i];
                b1_q[i]    <= b1_d[i];
                b2_q[i]    <= b2_d[i];
            end
            standing_q   <= standing_d;
            cur_frame_q  <= cur_frame_d;
            cur_player_q <= cur_player_d;
            roll_num_q   <= roll_num_d;
            strike1_q    <= strike1_d;
            roll_err_q   <= roll_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        b1_d         = b1_q;
        b2_d         = b2_q;
        standing_d   = standing_q;
        cur_frame_d  = cur_frame_q;
        cur_player_d = cur_player_q;
        roll_num_d   = roll_num_q;
        strike1_d    = strike1_q;
        roll_err_d   = 1'b0;
        end_turn     = 1'b0;

        if (new_game) begin
            state_d      = S_ROLL1;
            for (int i = 0; i < MAXP; i++) begin
                score_d[i] = '0;
                b1_d[i]    = 2'd0;
                b2_d[i]    = 1'b0;
            end
            standing_d   = PINS;
            cur_frame_d  = 4'd0;
            cur_player_d = 2'd0;
            roll_num_d   = 2'd0;
            strike1_d    = 1'b0;
        end else if (accept && !legal) begin
            roll_err_d = 1'b1;
        end else if (accept) begin
            score_d[cur_player_q] = score_q[cur_player_q] + {4'b0000, prod};

            // b1 weights the next roll, b2 the one after; consuming a roll
            // shifts b2 into b1 and adds any bonus this roll earns.
            if (final_frame) begin
                b1_d[cur_player_q] = {1'b0, b2_q[cur_player_q]};
                b2_d[cur_player_q] = 1'b0;
            end else if (state_q == S_ROLL1 && all_down) begin
                b1_d[cur_player_q] = {1'b0, b2_q[cur_player_q]} + 2'd1;
                b2_d[cur_player_q] = 1'b1;
            end else if (state_q == S_ROLL2 && roll_pins == standing_q) begin
                b1_d[cur_player_q] = {1'b0, b2_q[cur_player_q]} + 2'd1;
                b2_d[cur_player_q] = 1'b0;
            end else begin
                b1_d[cur_player_q] = {1'b0, b2_q[cur_player_q]};
                b2_d[cur_player_q] = 1'b0;
            end

            case (state_q)
                S_ROLL1: begin
                    if (!final_frame) begin
                        if (all_down) begin
                            end_turn = 1'b1;
                        end else begin
                            standing_d = left_after;
                            roll_num_d = 2'd1;
                            state_d    = S_ROLL2;
                        end
                    end else begin
                        strike1_d  = all_down;
                        standing_d = all_down ? PINS : fresh_left;
                        roll_num_d = 2'd1;
                        state_d    = S_ROLL2;
                    end
                end
                S_ROLL2: begin
                    if (!final_frame) begin
                        end_turn = 1'b1;
                    end else if (strike1_q) begin
                        // After a final-frame strike the rack is reset on
                        // another strike, otherwise the fill ball shoots
                        // at what is left.
                        standing_d = all_down ? PINS : fresh_left;
                        roll_num_d = 2'd2;
                        state_d    = S_FILL;
                    end else if (roll_pins == standing_q) begin
                        standing_d = PINS;
                        roll_num_d = 2'd2;
                        state_d    = S_FILL;
                    end else begin
                        end_turn = 1'b1;
                    end
                end
                S_FILL: begin
                    end_turn = 1'b1;
                end
                default: begin
                end
            endcase

            if (end_turn) begin
                standing_d = PINS;
                roll_num_d = 2'd0;
                strike1_d  = 1'b0;
                state_d    = S_ROLL1;
                if (cur_player_q == LAST_PLAYER) begin
                    cur_player_d = 2'd0;
                    if (final_frame) begin
                        state_d = S_OVER;
                    end else begin
                        cur_frame_d = cur_frame_q + 4'd1;
                    end
                end else begin
                    cur_player_d = cur_player_q + 2'd1;
                end
            end
        end
    end

    assign roll_err   = roll_err_q;
    assign cur_player = cur_player_q;
    assign cur_frame  = cur_frame_q;
    assign roll_num   = roll_num_q;
    assign game_over  = (state_q == S_OVER);
    assign disp_score = ({1'b0, disp_sel} < NP) ? score_q[disp_sel] : '0;

    score_hex3 u_hex (
        .score (disp_score),
        .hex2  (HEX2),
        .hex1  (HEX1),
        .hex0  (HEX0)
    );

endmodule
`default_nettype wire
